// File: rtl/serdesphy_ana_cdr_pkg.sv
// Shared types for the 4x-oversampling CDR: FSM state and phase-detector vote encodings.
package serdesphy_ana_cdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } cdr_state_t;

  typedef enum logic [1:0] {
    VOTE_NONE = 2'd0,
    VOTE_UP   = 2'd1,
    VOTE_DOWN = 2'd2
  } vote_t;

  localparam logic [1:0] PHASE_RESET = 2'd2;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/serdesphy_ana_cdr_phase_det.sv
// Combinational edge detector and early/late voter for one 4-sample word.
module serdesphy_ana_cdr_phase_det
  import serdesphy_ana_cdr_pkg::*;
(
  input  logic [3:0] rx_samples,
  input  logic       prev_s3,
  input  logic [1:0] phase_sel,
  output vote_t      vote,
  output logic       has_edge,
  output logic       multi_edge
);

  logic [3:0] e;
  logic [2:0] n_edges;
  logic [1:0] k;
  logic [1:0] ph_late;
  logic [1:0] ph_early;

  always_comb begin
    e = {rx_samples[3] ^ rx_samples[2],
         rx_samples[2] ^ rx_samples[1],
         rx_samples[1] ^ rx_samples[0],
         rx_samples[0] ^ prev_s3};
    n_edges    = popcount4(e);
    has_edge   = |e;
    multi_edge = (n_edges > 3'd1);
    ph_late    = phase_sel + 2'd1;
    ph_early   = phase_sel + 2'd3;
    k = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (e[i]) k = 2'(i);
    end
    // Edges at phase_sel or opposite it carry no timing information.
    vote = VOTE_NONE;
    if (n_edges == 3'd1) begin
      if (k == ph_late)       vote = VOTE_UP;
      else if (k == ph_early) vote = VOTE_DOWN;
    end
  end

endmodule

// File: rtl/serdesphy_ana_cdr.sv
// Digital CDR: picks one of four oversampled phases with an integrating
// phase detector, and tracks lock with stable-cycle and edge-free counters.
//
// state    | meaning
// ST_IDLE  | disabled or first enabled cycle; counters cleared, outputs at reset values
// ST_ACQUIRE | tracking phase, counting step-free cycles toward lock
// ST_LOCKED | cdr_lock high; wrap slip or edge starvation drops back to ACQUIRE
module serdesphy_ana_cdr
  import serdesphy_ana_cdr_pkg::*;
#(
  parameter int LOCK_COUNT    = 240,
  parameter int INT_THRESH    = 8,
  parameter int NO_EDGE_LIMIT = 64
) (
  input  logic       clk_240m,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] rx_samples,
  output logic       rx_bit,
  output logic       rx_bit_valid,
  output logic [1:0] phase_sel,
  output logic       cdr_lock,
  output logic       slip,
  output logic       edge_err
);

  localparam logic signed [4:0] INT_POS    = 5'(INT_THRESH);
  localparam logic signed [4:0] INT_NEG    = -INT_POS;
  localparam logic [9:0]        STABLE_TC  = 10'(LOCK_COUNT - 1);
  localparam logic [6:0]        NO_EDGE_TC = 7'(NO_EDGE_LIMIT);

  cdr_state_t        state;
  logic signed [4:0] integ;
  logic [9:0]        stable_cnt;
  logic [6:0]        no_edge_cnt;
  logic              prev_s3;

  vote_t             vote;
  logic              has_edge;
  logic              multi_edge;
  logic signed [4:0] integ_sum;
  logic              step_up;
  logic              step_dn;
  logic              wrap;
  logic [1:0]        phase_nxt;
  logic [6:0]        no_edge_nxt;

  serdesphy_ana_cdr_phase_det u_phase_det (
    .rx_samples (rx_samples),
    .prev_s3    (prev_s3),
    .phase_sel  (phase_sel),
    .vote       (vote),
    .has_edge   (has_edge),
    .multi_edge (multi_edge)
  );

  always_comb begin
    integ_sum = integ;
    if (vote == VOTE_UP)        integ_sum = integ + 5'sd1;
    else if (vote == VOTE_DOWN) integ_sum = integ - 5'sd1;
    step_up   = (vote == VOTE_UP)   && (integ_sum == INT_POS);
    step_dn   = (vote == VOTE_DOWN) && (integ_sum == INT_NEG);
    phase_nxt = phase_sel;
    if (step_up)      phase_nxt = phase_sel + 2'd1;
    else if (step_dn) phase_nxt = phase_sel - 2'd1;
    wrap = (step_up && phase_sel == 2'd3) || (step_dn && phase_sel == 2'd0);
    if (has_edge)                 no_edge_nxt = 7'd0;
    else if (&no_edge_cnt)        no_edge_nxt = no_edge_cnt;
    else                          no_edge_nxt = no_edge_cnt + 7'd1;
  end

  always_ff @(posedge clk_240m or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      integ        <= '0;
      stable_cnt   <= '0;
      no_edge_cnt  <= '0;
      prev_s3      <= 1'b0;
      phase_sel    <= PHASE_RESET;
      rx_bit       <= 1'b0;
      rx_bit_valid <= 1'b0;
      cdr_lock     <= 1'b0;
      slip         <= 1'b0;
      edge_err     <= 1'b0;
    end else if (!enable) begin
      // phase_sel, integ and prev_s3 hold so tracking resumes where it left off
      state        <= ST_IDLE;
      stable_cnt   <= '0;
      no_edge_cnt  <= '0;
      rx_bit       <= 1'b0;
      rx_bit_valid <= 1'b0;
      cdr_lock     <= 1'b0;
      slip         <= 1'b0;
      edge_err     <= 1'b0;
    end else begin
      prev_s3      <= rx_samples[3];
      rx_bit       <= 1'b0;
      rx_bit_valid <= 1'b0;
      slip         <= 1'b0;
      edge_err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          state       <= ST_ACQUIRE;
          stable_cnt  <= '0;
          no_edge_cnt <= '0;
          cdr_lock    <= 1'b0;
        end
        default: begin
          rx_bit       <= rx_samples[phase_sel];
          rx_bit_valid <= 1'b1;
          edge_err     <= multi_edge;
          slip         <= wrap;
          integ        <= (step_up || step_dn) ? 5'sd0 : integ_sum;
          phase_sel    <= phase_nxt;
          no_edge_cnt  <= no_edge_nxt;
          if (state == ST_ACQUIRE) begin
            if (step_up || step_dn) begin
              stable_cnt <= '0;
            end else if (stable_cnt == STABLE_TC) begin
              state    <= ST_LOCKED;
              cdr_lock <= 1'b1;
            end else begin
              stable_cnt <= stable_cnt + 10'd1;
            end
          end else if (wrap || no_edge_nxt == NO_EDGE_TC) begin
            state       <= ST_ACQUIRE;
            cdr_lock    <= 1'b0;
            stable_cnt  <= '0;
            no_edge_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serdesphy_ana_cdr.sv
// Directed bench for serdesphy_ana_cdr; recovered bits are checked through a FIFO scoreboard.
`timescale 1ns/100ps
module tb_serdesphy_ana_cdr;

  logic       clk_240m = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] rx_samples;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic [1:0] phase_sel;
  logic       cdr_lock;
  logic       slip;
  logic       edge_err;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic exp_q[$];
  logic [1:0] exp_phase;
  logic last_s3;
  logic active;
  logic sb_exp;

  always #5 clk_240m = ~clk_240m;

  serdesphy_ana_cdr dut (
    .clk_240m     (clk_240m),
    .rst          (rst),
    .enable       (enable),
    .rx_samples   (rx_samples),
    .rx_bit       (rx_bit),
    .rx_bit_valid (rx_bit_valid),
    .phase_sel    (phase_sel),
    .cdr_lock     (cdr_lock),
    .slip         (slip),
    .edge_err     (edge_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // k = 0..3 puts the single transition at sample k; k = 4 gives no transition
  function automatic logic [3:0] edge_word(input int k, input logic last);
    logic [3:0] w;
    for (int b = 0; b < 4; b++) w[b] = (b < k) ? last : ~last;
    return w;
  endfunction

  task automatic cycle(input logic [3:0] w);
    @(negedge clk_240m);
    rx_samples = w;
    if (enable) begin
      if (active) exp_q.push_back(w[exp_phase]);
      last_s3 = w[3];
      active  = 1'b1;
    end else begin
      active = 1'b0;
    end
    @(posedge clk_240m);
    #1;
  endtask

  task automatic edges(input int k, input int n);
    for (int i = 0; i < n; i++) cycle(edge_word(k, last_s3));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_bit"},   32'(rx_bit),       32'd0);
    check({tag, "_valid"},    32'(rx_bit_valid), 32'd0);
    check({tag, "_phase"},    32'(phase_sel),    32'd2);
    check({tag, "_lock"},     32'(cdr_lock),     32'd0);
    check({tag, "_slip"},     32'(slip),         32'd0);
    check({tag, "_edge_err"}, 32'(edge_err),     32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    rx_samples = 4'h0;
    exp_q.delete();
    active = 1'b0;
    last_s3 = 1'b0;
    exp_phase = 2'd2;
    repeat (2) @(negedge clk_240m);
    rst = 1'b0;
    @(posedge clk_240m);
    #1;
  endtask

  always @(negedge clk_240m) begin
    if (rst === 1'b0 && rx_bit_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rx_bit_sb: valid with no expected bit, got %0b at %0t", rx_bit, $time);
      end else begin
        sb_exp = exp_q.pop_front();
        if (rx_bit === sb_exp) n_pass++;
        else $display("FAIL rx_bit_sb: got %0b expected %0b at %0t", rx_bit, sb_exp, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_reset_outputs("rst_init");

    // lock on an edge-at-0 pattern: no votes, lock visible after enabled cycle 241
    enable = 1'b1;
    for (int i = 1; i <= 241; i++) begin
      cycle(edge_word(0, last_s3));
      if (i == 240) check("lock_pre_241", 32'(cdr_lock), 32'd0);
      if (i == 241) check("lock_at_241", 32'(cdr_lock), 32'd1);
    end
    check("lock_phase_kept", 32'(phase_sel), 32'd2);

    // edge starvation: the 64th edge-free cycle drops lock
    edges(4, 63);
    check("noedge_63_locked", 32'(cdr_lock), 32'd1);
    edges(4, 1);
    check("noedge_64_unlock", 32'(cdr_lock), 32'd0);
    check("noedge_acq_valid", 32'(rx_bit_valid), 32'd1);

    // back in ACQUIRE with counters cleared: relock after exactly 240 cycles
    edges(0, 239);
    check("relock_pre", 32'(cdr_lock), 32'd0);
    edges(0, 1);
    check("relock", 32'(cdr_lock), 32'd1);

    // asynchronous reset between clock edges
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("rst_async");
    do_reset();

    // late edges step phase 2->3, then edges one sample later step 3->0 with slip
    enable = 1'b1;
    edges(4, 1);
    edges(3, 7);
    check("up_7_phase", 32'(phase_sel), 32'd2);
    edges(3, 1);
    check("up_8_phase", 32'(phase_sel), 32'd3);
    check("up_8_noslip", 32'(slip), 32'd0);
    exp_phase = 2'd3;
    edges(0, 7);
    check("wrap_7_phase", 32'(phase_sel), 32'd3);
    edges(0, 1);
    check("wrap_phase", 32'(phase_sel), 32'd0);
    check("wrap_slip", 32'(slip), 32'd1);
    exp_phase = 2'd0;
    edges(4, 1);
    check("slip_one_cycle", 32'(slip), 32'd0);

    // multi-edge word flags edge_err and leaves the integrator untouched
    cycle(4'b0101);
    check("edge_err_pulse", 32'(edge_err), 32'd1);
    edges(4, 1);
    check("edge_err_clear", 32'(edge_err), 32'd0);
    edges(1, 7);
    check("post_err_7_phase", 32'(phase_sel), 32'd0);
    edges(1, 1);
    check("post_err_8_phase", 32'(phase_sel), 32'd1);
    exp_phase = 2'd1;

    // disable mid-run: outputs clear, phase and integrator hold (3 + 5 votes step)
    edges(2, 3);
    enable = 1'b0;
    cycle(4'h0);
    cycle(4'h0);
    check("dis_valid", 32'(rx_bit_valid), 32'd0);
    check("dis_lock", 32'(cdr_lock), 32'd0);
    check("dis_phase_hold", 32'(phase_sel), 32'd1);
    enable = 1'b1;
    edges(4, 1);
    edges(2, 4);
    check("resume_4_phase", 32'(phase_sel), 32'd1);
    edges(2, 1);
    check("resume_5_phase", 32'(phase_sel), 32'd2);
    exp_phase = 2'd2;

    // early edges step 2->1 and restart the stable counter
    do_reset();
    enable = 1'b1;
    edges(4, 1);
    edges(1, 7);
    check("dn_7_phase", 32'(phase_sel), 32'd2);
    edges(1, 1);
    check("dn_8_phase", 32'(phase_sel), 32'd1);
    check("dn_8_noslip", 32'(slip), 32'd0);
    exp_phase = 2'd1;
    edges(1, 239);
    check("restart_pre_lock", 32'(cdr_lock), 32'd0);
    edges(1, 1);
    check("restart_lock", 32'(cdr_lock), 32'd1);

    // non-wrapping step keeps lock; wrapping step 0->3 drops it
    edges(0, 8);
    check("locked_step_phase", 32'(phase_sel), 32'd0);
    check("locked_step_keep", 32'(cdr_lock), 32'd1);
    check("locked_step_noslip", 32'(slip), 32'd0);
    exp_phase = 2'd0;
    edges(3, 8);
    check("locked_wrap_phase", 32'(phase_sel), 32'd3);
    check("locked_wrap_slip", 32'(slip), 32'd1);
    check("locked_wrap_unlock", 32'(cdr_lock), 32'd0);
    exp_phase = 2'd3;
    edges(4, 2);

    @(negedge clk_240m);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
